// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRA/ROR/SRL) with one register stage per shift level
// and valid/ready on both sides. Define SHIFT_PIPE_CARRY_EN to add carry_out.
module shift_pipe #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout
`ifdef SHIFT_PIPE_CARRY_EN
  ,
  output logic             carry_out
`endif
);

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRA = 2'b01,
    MODE_ROR = 2'b10,
    MODE_SRL = 2'b11
  } mode_e;

  // Stage k keeps only the SHW-1-k shamt bits still to be consumed; they are
  // packed back to back in w_rem, stage k starting at sh_off(k).
  function automatic int sh_off(input int k);
    return k * (SHW - 1) - (k * (k - 1)) / 2;
  endfunction

  localparam int SHT = SHW * (SHW - 1) / 2;

  logic             w_valid [SHW];
  logic [WIDTH-1:0] w_data  [SHW];
  logic [1:0]       w_mode  [SHW-1];
  logic [SHT-1:0]   w_rem;
  logic [SHW:0]     w_ready;
`ifdef SHIFT_PIPE_CARRY_EN
  logic             w_carry [SHW];
`endif

  assign w_ready[SHW] = out_ready;
  assign in_ready     = w_ready[0];

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int STEP = 1 << (SHW - 1 - k);
    localparam int IN_W = SHW - k;

    logic             w_up_valid;
    logic [1:0]       w_up_mode;
    logic [IN_W-1:0]  w_up_rem;
    logic [WIDTH-1:0] w_up_data;
    logic [WIDTH-1:0] w_next_data;
    logic             w_apply;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    if (k == 0) begin : g_src_port
      assign w_up_valid = in_valid;
      assign w_up_mode  = mode;
      assign w_up_rem   = shamt;
      assign w_up_data  = din;
    end else begin : g_src_stage
      assign w_up_valid = w_valid[k-1];
      assign w_up_mode  = w_mode[k-1];
      assign w_up_rem   = w_rem[sh_off(k-1) +: IN_W];
      assign w_up_data  = w_data[k-1];
    end

    assign w_apply    = w_up_rem[IN_W-1];
    assign w_ready[k] = !r_valid || w_ready[k+1];

    // NOTE: default assignment first so every path drives w_next_data; without it a latch is inferred.
    always_comb begin
      w_next_data = w_up_data;
      if (w_apply) begin
        case (mode_e'(w_up_mode))
          MODE_SLL: w_next_data = w_up_data << STEP;
          MODE_SRA: w_next_data = $signed(w_up_data) >>> STEP;
          MODE_ROR: w_next_data = (w_up_data >> STEP) | (w_up_data << (WIDTH - STEP));
          MODE_SRL: w_next_data = w_up_data >> STEP;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_data  <= '0;
      end else begin
        // NOTE: non-blocking so every stage captures its upstream's pre-edge value.
        // flush is checked outside the ready gate so stalled entries are squashed too.
        if (flush)           r_valid <= 1'b0;
        else if (w_ready[k]) r_valid <= w_up_valid;
        if (w_ready[k])      r_data  <= w_next_data;
      end
    end

    assign w_valid[k] = r_valid;
    assign w_data[k]  = r_data;

    // The final stage has no downstream consumer for mode or shamt.
    if (k < SHW - 1) begin : g_fwd
      logic [1:0]      r_mode;
      logic [IN_W-2:0] r_rem;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mode <= '0;
          r_rem  <= '0;
        end else if (w_ready[k]) begin
          r_mode <= w_up_mode;
          r_rem  <= w_up_rem[IN_W-2:0];
        end
      end

      assign w_mode[k]                   = r_mode;
      assign w_rem[sh_off(k) +: IN_W-1]  = r_rem;
    end

`ifdef SHIFT_PIPE_CARRY_EN
    logic w_up_carry;
    logic w_next_carry;
    logic r_carry;

    if (k == 0) begin : g_carry_port
      assign w_up_carry = 1'b0;
    end else begin : g_carry_stage
      assign w_up_carry = w_carry[k-1];
    end

    // A shifting stage replaces the carry with the last bit it pushed out.
    always_comb begin
      w_next_carry = w_up_carry;
      if (w_apply) begin
        if (mode_e'(w_up_mode) == MODE_SLL) w_next_carry = w_up_data[WIDTH-STEP];
        else                                w_next_carry = w_up_data[STEP-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          r_carry <= 1'b0;
      else if (w_ready[k]) r_carry <= w_next_carry;
    end

    assign w_carry[k] = r_carry;
`endif
  end

  assign out_valid = w_valid[SHW-1];
  assign dout      = w_data[SHW-1];
`ifdef SHIFT_PIPE_CARRY_EN
  assign carry_out = w_carry[SHW-1];
`endif

endmodule
